qos_wrr_scheduler: RTL and testbench
====================================

Name: qos_wrr_scheduler

Overview:
- Weighted round-robin scheduler draining the four virtual-channel FIFOs (VC0..VC3) of the QoS module onto a single shared egress path.
- Consumes the packed 4-bit EMPTY/ALMOST_EMPTY flag vectors produced by the flag connector and issues one-hot pops.
- Honors per-VC burst weights and downstream backpressure.
- Sits between the VC FIFO bank and the egress FIFO/PCIe link interface.

Parameters:
- W0, 4: max consecutive pops per VC0 grant (0 = VC never served).
- W1, 3: same for VC1.
- W2, 2: same for VC2.
- W3, 1: same for VC3.
- CNT_W, 4: credit counter width; each Wn must be ≤ 2^CNT_W−1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_L  in  1  asynchronous active-low reset.
- ENABLE  in  1  scheduler enable; low forces IDLE.
- EMPTY_IN  in  4  per-VC FIFO empty flags, bit n = VCn.
- ALMOST_EMPTY_IN  in  4  per-VC FIFO almost-empty flags.
- DEST_FULL_IN  in  1  downstream almost-full; stalls pops.
- POP_OUT  out  4  one-hot FIFO read strobe (Mealy, combinational from state regs and inputs).
- VC_SEL_OUT  out  2  VC index of data valid this cycle (registered).
- VALID_OUT  out  1  FIFO read data valid this cycle (registered, POP delayed 1 cycle).
- IDLE_OUT  out  1  high when FSM is in IDLE (registered).

Behaviour:
- Reset (RESET_L low, async): state=IDLE, RR_PTR=0, CREDIT=0, CUR_VC=0, VALID_OUT=0, VC_SEL_OUT=0, IDLE_OUT=1, POP_OUT=0.
- FIFO read latency is 1 cycle: VALID_OUT/VC_SEL_OUT at cycle t+1 equal |POP_OUT / CUR_VC at cycle t.
- State IDLE:
  - POP_OUT=0.
  - If ENABLE and any VC eligible (EMPTY_IN[n]=0 and Wn≠0), go to SELECT next cycle.
- State SELECT (1 cycle, no pop):
  - Scan RR_PTR, RR_PTR+1, ... mod 4; first eligible VC becomes CUR_VC, CREDIT←W[CUR_VC], go to SERVE.
  - If none is eligible (flags changed), go to IDLE.
- State SERVE:
  - POP_OUT[CUR_VC]=1 iff ENABLE & !EMPTY_IN[CUR_VC] & !DEST_FULL_IN; all other bits 0.
  - On each pop, CREDIT decrements.
  - Exit to SELECT with RR_PTR←CUR_VC+1 (mod 4, 2-bit wrap) after a pop if CREDIT==1 or ALMOST_EMPTY_IN[CUR_VC]=1. The almost-empty exit guarantees no back-to-back pop underflows the FIFO.
  - EMPTY_IN[CUR_VC]=1 with no pop: exit to SELECT, RR_PTR←CUR_VC+1.
  - DEST_FULL_IN=1: hold in SERVE, no pop, CREDIT unchanged, no pointer advance.
  - ENABLE low (any state): go to IDLE next cycle, no pop that cycle, RR_PTR unchanged. An in-flight VALID_OUT still completes.
- Simultaneous DEST_FULL_IN and EMPTY_IN in SERVE: EMPTY takes precedence (exit).
- Invariants:
  - POP_OUT is never multi-hot.
  - POP_OUT is never asserted to a VC whose EMPTY_IN is high.
  - A VC with Wn=0 is never popped.
- Reset mid-burst: immediate return to reset values; no pop after RESET_L falls.

Optional Feature:
- Macro: QOS_STRICT_PRIO_EN.
- Defined: VC0 is strict priority.
  - SELECT picks VC0 whenever eligible, regardless of RR_PTR.
  - While serving VC1..VC3, a pop made while EMPTY_IN[0]=0 ends the burst (→SELECT). RR_PTR still advances past the preempted VC.
  - VC0 bursts are still limited by W0.
- Undefined: pure weighted round-robin as above; VC0 treated like the other VCs.

Test Plan:
- All VCs non-empty, ALMOST_EMPTY=0, DEST_FULL=0, ENABLE=1 from reset → repeating pop pattern VC0×4, VC1×3, VC2×2, VC3×1, with one SELECT bubble cycle between bursts; VALID_OUT follows POP by 1 cycle with matching VC_SEL_OUT.
- Only VC2 non-empty, ALMOST_EMPTY_IN[2] rising on 2nd pop → exactly 2 pops to VC2, then SELECT; VC2 is re-selected only if EMPTY_IN[2] is still 0; never popped while empty.
- VC1 in SERVE with CREDIT=3; DEST_FULL_IN high for 5 cycles after the first pop → POP_OUT=0 for those 5 cycles, then 2 more VC1 pops, then move to VC2.
- W3=0, only VC3 non-empty → FSM stays IDLE, POP_OUT=0, IDLE_OUT=1.
- RESET_L pulsed low mid-burst on VC0 → POP_OUT, VALID_OUT drop in the same cycle; IDLE_OUT=1; after release, arbitration restarts at VC0.
- QOS_STRICT_PRIO_EN defined: serving VC3 (W3=1 raised to 3 via param) when EMPTY_IN[0] falls → current pop completes, next grant is VC0, then RR resumes at VC0+... with RR_PTR pointing past VC3.

Source files
------------

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin drain of four VC FIFOs onto one egress path with 1-cycle read latency.
// Optional VC0 strict priority is enabled by defining QOS_STRICT_PRIO_EN.
module qos_wrr_scheduler #(
  parameter int unsigned W0    = 4,
  parameter int unsigned W1    = 3,
  parameter int unsigned W2    = 2,
  parameter int unsigned W3    = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       ENABLE,
  input  logic [3:0] EMPTY_IN,
  input  logic [3:0] ALMOST_EMPTY_IN,
  input  logic       DEST_FULL_IN,
  output logic [3:0] POP_OUT,
  output logic [1:0] VC_SEL_OUT,
  output logic       VALID_OUT,
  output logic       IDLE_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SERVE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] WT0 = CNT_W'(W0);
  localparam logic [CNT_W-1:0] WT1 = CNT_W'(W1);
  localparam logic [CNT_W-1:0] WT2 = CNT_W'(W2);
  localparam logic [CNT_W-1:0] WT3 = CNT_W'(W3);
  localparam logic [3:0] WT_NZ = {(W3 != 32'd0), (W2 != 32'd0), (W1 != 32'd0), (W0 != 32'd0)};

  function automatic logic [CNT_W-1:0] weight_of(input logic [1:0] vc);
    case (vc)
      2'd0:    weight_of = WT0;
      2'd1:    weight_of = WT1;
      2'd2:    weight_of = WT2;
      2'd3:    weight_of = WT3;
      default: weight_of = WT3;
    endcase
  endfunction

  // Returns {found, index}; scanning far-to-near lets the VC nearest the pointer win.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (elig[idx]) begin
        rr_pick = {1'b1, idx};
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       cur_vc_q, cur_vc_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             valid_q;
  logic [1:0]       vc_sel_q;
  logic             idle_q;

  logic [3:0] elig_s;
  logic [2:0] sel_s;
  logic       preempt_s;
  logic       pop_ok_s;

  assign elig_s = ~EMPTY_IN & WT_NZ;

  // Winner of the next SELECT and whether the current burst must yield to VC0.
  always_comb begin
`ifdef QOS_STRICT_PRIO_EN
    if (elig_s[0]) begin
      sel_s = 3'b100;
    end else begin
      sel_s = rr_pick(elig_s, rr_ptr_q);
    end
    preempt_s = (cur_vc_q != 2'd0) && elig_s[0];
`else
    sel_s     = rr_pick(elig_s, rr_ptr_q);
    preempt_s = 1'b0;
`endif
  end

  // Mealy pop strobe; the weight guard keeps a zero-weight VC from ever being read.
  always_comb begin
    POP_OUT  = 4'b0000;
    pop_ok_s = (state_q == ST_SERVE) && ENABLE && !EMPTY_IN[cur_vc_q] &&
               !DEST_FULL_IN && WT_NZ[cur_vc_q];
    if (pop_ok_s) begin
      POP_OUT = 4'b0001 << cur_vc_q;
    end else begin
      POP_OUT = 4'b0000;
    end
  end

  // Next-state logic; EMPTY is tested before backpressure so an empty VC always exits.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_vc_d = cur_vc_q;
    credit_d = credit_q;
    if (!ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|elig_s) begin
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SELECT: begin
          if (sel_s[2]) begin
            cur_vc_d = sel_s[1:0];
            credit_d = weight_of(sel_s[1:0]);
            state_d  = ST_SERVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (EMPTY_IN[cur_vc_q]) begin
            state_d  = ST_SELECT;
            rr_ptr_d = cur_vc_q + 2'd1;
          end else if (pop_ok_s) begin
            credit_d = credit_q - CNT_W'(1);
            if ((credit_q == CNT_W'(1)) || ALMOST_EMPTY_IN[cur_vc_q] || preempt_s) begin
              state_d  = ST_SELECT;
              rr_ptr_d = cur_vc_q + 2'd1;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            state_d = ST_SERVE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, arbitration and registered output flops.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 2'd0;
      cur_vc_q <= 2'd0;
      credit_q <= '0;
      valid_q  <= 1'b0;
      vc_sel_q <= 2'd0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_vc_q <= cur_vc_d;
      credit_q <= credit_d;
      valid_q  <= |POP_OUT;
      vc_sel_q <= cur_vc_q;
      idle_q   <= (state_d == ST_IDLE);
    end
  end

  assign VALID_OUT  = valid_q;
  assign VC_SEL_OUT = vc_sel_q;
  assign IDLE_OUT   = idle_q;

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Bench for qos_wrr_scheduler: default-weight DUT plus a W3=0 DUT on shared random stimulus,
// checked every cycle against a burst-level model, with literal directed sequences pinning it.
module tb_qos_wrr_scheduler;

  logic       clk_s = 1'b0;
  logic       rst_n_s;
  logic       enable_s;
  logic [3:0] empty_s;
  logic [3:0] aempty_s;
  logic       dest_full_s;
  logic [3:0] pop_a_s, pop_b_s;
  logic [1:0] sel_a_s, sel_b_s;
  logic       val_a_s, val_b_s, idle_a_s, idle_b_s;

  always #5 clk_s = ~clk_s;

  qos_wrr_scheduler dut_a (
    .CLK(clk_s), .RESET_L(rst_n_s), .ENABLE(enable_s), .EMPTY_IN(empty_s),
    .ALMOST_EMPTY_IN(aempty_s), .DEST_FULL_IN(dest_full_s), .POP_OUT(pop_a_s),
    .VC_SEL_OUT(sel_a_s), .VALID_OUT(val_a_s), .IDLE_OUT(idle_a_s)
  );

  qos_wrr_scheduler #(.W3(0)) dut_b (
    .CLK(clk_s), .RESET_L(rst_n_s), .ENABLE(enable_s), .EMPTY_IN(empty_s),
    .ALMOST_EMPTY_IN(aempty_s), .DEST_FULL_IN(dest_full_s), .POP_OUT(pop_b_s),
    .VC_SEL_OUT(sel_b_s), .VALID_OUT(val_b_s), .IDLE_OUT(idle_b_s)
  );

  int n_vec = 0;
  int n_err = 0;

  int wt [2][4] = '{'{4, 3, 2, 1}, '{4, 3, 2, 0}};
  // Model: mode 0 = idle, 1 = choosing the next VC, 2 = bursting on m_cur.
  int m_mode [2];
  int m_ptr [2];
  int m_cur [2];
  int m_credit [2];
  int m_valid [2];
  int m_vcsel [2];

  typedef struct {
    bit         en;
    logic [3:0] empty;
    logic [3:0] ae;
    bit         full;
    int         pop;
  } step_t;
  step_t steps[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit elig(input int k, input int n);
    return !empty_s[n] && (wt[k][n] != 0);
  endfunction

  function automatic int vc_of(input int onehot);
    for (int n = 0; n < 4; n++) if (onehot == (1 << n)) return n;
    return -1;
  endfunction

  task automatic model_cycle(input int k, input int act_pop, input int act_sel,
                             input int act_val, input int act_idle);
    int  pv;
    int  pick;
    bit  strict;
    bit  any;
`ifdef QOS_STRICT_PRIO_EN
    strict = 1'b1;
`else
    strict = 1'b0;
`endif
    if (!rst_n_s) begin
      m_mode[k] = 0; m_ptr[k] = 0; m_cur[k] = 0; m_credit[k] = 0;
      m_valid[k] = 0; m_vcsel[k] = 0;
      chk($sformatf("rst_pop[%0d]", k), act_pop, 0);
      chk($sformatf("rst_valid[%0d]", k), act_val, 0);
      chk($sformatf("rst_idle[%0d]", k), act_idle, 1);
      chk($sformatf("rst_sel[%0d]", k), act_sel, 0);
    end else begin
      pv = -1;
      if (m_mode[k] == 2 && enable_s && !empty_s[m_cur[k]] && !dest_full_s) pv = m_cur[k];
      chk($sformatf("pop[%0d]", k), act_pop, (pv < 0) ? 0 : (1 << pv));
      chk($sformatf("valid[%0d]", k), act_val, m_valid[k]);
      chk($sformatf("idle[%0d]", k), act_idle, (m_mode[k] == 0) ? 1 : 0);
      if (m_valid[k] != 0) chk($sformatf("vc_sel[%0d]", k), act_sel, m_vcsel[k]);
      m_valid[k] = (pv >= 0) ? 1 : 0;
      if (pv >= 0) m_vcsel[k] = pv;
      if (!enable_s) begin
        m_mode[k] = 0;
      end else if (m_mode[k] == 0) begin
        any = 1'b0;
        for (int n = 0; n < 4; n++) if (elig(k, n)) any = 1'b1;
        if (any) m_mode[k] = 1;
      end else if (m_mode[k] == 1) begin
        pick = -1;
        if (strict && elig(k, 0)) pick = 0;
        for (int s = 0; s < 4; s++)
          if (pick < 0 && elig(k, (m_ptr[k] + s) % 4)) pick = (m_ptr[k] + s) % 4;
        if (pick < 0) begin
          m_mode[k] = 0;
        end else begin
          m_cur[k] = pick; m_credit[k] = wt[k][pick]; m_mode[k] = 2;
        end
      end else begin
        if (empty_s[m_cur[k]]) begin
          m_mode[k] = 1; m_ptr[k] = (m_cur[k] + 1) % 4;
        end else if (!dest_full_s) begin
          m_credit[k] = m_credit[k] - 1;
          if (m_credit[k] == 0 || aempty_s[m_cur[k]] || (strict && m_cur[k] != 0 && elig(k, 0))) begin
            m_mode[k] = 1; m_ptr[k] = (m_cur[k] + 1) % 4;
          end
        end
      end
    end
  endtask

  // Compare process: outputs are stable mid-cycle, inputs only move just after the rising edge.
  always @(negedge clk_s) begin
    model_cycle(0, int'(pop_a_s), int'(sel_a_s), int'(val_a_s), int'(idle_a_s));
    model_cycle(1, int'(pop_b_s), int'(sel_b_s), int'(val_b_s), int'(idle_b_s));
  end

  task automatic add(input bit en, input logic [3:0] e, input logic [3:0] a, input bit f, input int p);
    steps.push_back('{en, e, a, f, p});
  endtask

  task automatic run_steps(input string tag);
    for (int i = 0; i < steps.size(); i++) begin
      enable_s = steps[i].en; empty_s = steps[i].empty;
      aempty_s = steps[i].ae; dest_full_s = steps[i].full;
      @(negedge clk_s); #1;
      chk($sformatf("%s_pop[%0d]", tag, i), int'(pop_a_s), steps[i].pop);
      if (i > 0) begin
        chk($sformatf("%s_valid[%0d]", tag, i), int'(val_a_s), (steps[i-1].pop != 0) ? 1 : 0);
        if (steps[i-1].pop != 0)
          chk($sformatf("%s_sel[%0d]", tag, i), int'(sel_a_s), vc_of(steps[i-1].pop));
      end
      @(posedge clk_s); #1;
    end
    steps.delete();
  endtask

  task automatic do_reset();
    rst_n_s = 1'b0;
    @(negedge clk_s); #1;
    chk("lit_rst_pop", int'(pop_a_s), 0);
    chk("lit_rst_valid", int'(val_a_s), 0);
    chk("lit_rst_idle", int'(idle_a_s), 1);
    chk("lit_rst_sel", int'(sel_a_s), 0);
    @(posedge clk_s); #1;
    rst_n_s = 1'b1;
  endtask

  int seq_a [20] = '{0, 0, 1, 1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 0, 8, 0, 1, 1, 1, 1};
  int seq_r [8]  = '{0, 0, 1, 1, 1, 1, 0, 2};
  int seq_f [13] = '{0, 0, 2, 0, 0, 0, 0, 0, 2, 2, 0, 4, 4};

  initial begin
    rst_n_s = 1'b0; enable_s = 1'b0; empty_s = 4'hF; aempty_s = 4'h0; dest_full_s = 1'b0;
    repeat (2) @(posedge clk_s);
    #1;

    // All VCs backlogged: 4/3/2/1 bursts separated by one SELECT bubble.
    do_reset();
    foreach (seq_a[i]) add(1'b1, 4'b0000, 4'b0000, 1'b0, seq_a[i]);
    run_steps("wrr");

    // Reset in the middle of a VC0 burst, then arbitration restarts at VC0.
    do_reset();
    for (int i = 0; i < 4; i++) add(1'b1, 4'b0000, 4'b0000, 1'b0, seq_a[i]);
    run_steps("pre_rst");
    do_reset();
    foreach (seq_r[i]) add(1'b1, 4'b0000, 4'b0000, 1'b0, seq_r[i]);
    run_steps("post_rst");

    // VC1 stalled by DEST_FULL for 5 cycles after its first pop, then VC2.
    do_reset();
    foreach (seq_f[i]) add(1'b1, 4'b1001, 4'b0000, (i >= 3 && i <= 7), seq_f[i]);
    run_steps("full");

    // Only VC2 backlogged; almost-empty ends each burst after the flagged pop.
    do_reset();
    add(1'b1, 4'b1011, 4'b0000, 1'b0, 0);
    add(1'b1, 4'b1011, 4'b0000, 1'b0, 0);
    add(1'b1, 4'b1011, 4'b0000, 1'b0, 4);
    add(1'b1, 4'b1011, 4'b0100, 1'b0, 4);
    add(1'b1, 4'b1011, 4'b0100, 1'b0, 0);
    add(1'b1, 4'b1011, 4'b0100, 1'b0, 4);
    add(1'b1, 4'b1111, 4'b0100, 1'b0, 0);
    add(1'b1, 4'b1111, 4'b0100, 1'b0, 0);
    run_steps("ae");

    // Zero-weight VC3 as the only backlogged VC never leaves IDLE.
    do_reset();
    enable_s = 1'b1; empty_s = 4'b0111; aempty_s = 4'b0000; dest_full_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_s); #1;
      chk($sformatf("w0_pop[%0d]", i), int'(pop_b_s), 0);
      chk($sformatf("w0_idle[%0d]", i), int'(idle_b_s), 1);
      @(posedge clk_s); #1;
    end

    // Randomized traffic, backpressure, enable drops and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst_n_s     = ($urandom_range(0, 199) != 0);
      enable_s    = ($urandom_range(0, 15) != 0);
      empty_s     = 4'($urandom & $urandom);
      aempty_s    = 4'($urandom & $urandom);
      dest_full_s = ($urandom_range(0, 4) == 0);
      @(posedge clk_s); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
